level_controller: RTL and testbench



---
 rtl/level_controller.sv | 162 ++++++++++++++++
 tb/tb_level_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/level_controller.sv
// level_controller: one encoder and one select button shared across three
// 8-bit colour levels. A short press moves focus to the next channel, a long
// press zeroes the focused level, and encoder detents step the focused level
// with saturation. Every output comes straight from a flop.
module level_controller #(
   parameter int STEP        = 1,
   parameter int LONG_CYCLES = 2_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enc_a,
   input  logic       enc_b,
   input  logic       btn,
   output logic [7:0] level0,
   output logic [7:0] level1,
   output logic [7:0] level2,
   output logic [1:0] sel,
   output logic       cleared
);

   localparam int              HW        = $clog2(LONG_CYCLES + 1);
   // Counter value seen on the edge that takes the LONG_CYCLES-th high sample.
   localparam logic [HW-1:0]   HCNT_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0]   HCNT_ONE  = HW'(1);
   localparam logic [8:0]      STEP9     = 9'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HELD  = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [HW-1:0]   hcnt_q, hcnt_d;
   logic [1:0]      sel_q, sel_d;
   logic            cleared_q, cleared_d;
   logic            a_q, a_d;
   logic            armed_q, armed_d;

   // Decoded events shared by all three channels.
   logic            a_rise;
   logic            clear_en;

   logic [7:0]      level_all [3];

   // Nothing is acted on until one clock after reset release, so inputs
   // that are already high at release cannot produce a step or a press.
   always_comb begin
      a_d     = enc_a;
      armed_d = 1'b1;
      a_rise  = armed_q & enc_a & ~a_q;
   end

   // Previous-sample and arming flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a_q     <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         a_q     <= a_d;
         armed_q <= armed_d;
      end
   end

   // Button FSM: focus advances on release of a short press; a long press
   // clears the focused level once and then waits for release in HELD.
   always_comb begin
      state_d   = state_q;
      hcnt_d    = hcnt_q;
      sel_d     = sel_q;
      clear_en  = 1'b0;
      if (armed_q) begin
         case (state_q)
            IDLE: begin
               if (btn) begin
                  state_d = PRESS;
                  hcnt_d  = HCNT_ONE;
               end
            end
            PRESS: begin
               if (btn) begin
                  hcnt_d = hcnt_q + HCNT_ONE;
                  if (hcnt_q == HCNT_LAST) begin
                     clear_en = 1'b1;
                     state_d  = HELD;
                  end
               end else begin
                  sel_d   = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
                  state_d = IDLE;
               end
            end
            HELD: begin
               if (!btn) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
      cleared_d = clear_en;
   end

   // FSM state, hold counter, focus and clear pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         hcnt_q    <= '0;
         sel_q     <= 2'd0;
         cleared_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hcnt_q    <= hcnt_d;
         sel_q     <= sel_d;
         cleared_q <= cleared_d;
      end
   end

   // One saturating level register per channel; only the focused one moves.
   for (genvar gi = 0; gi < 3; gi++) begin : g_level
      logic [7:0] lvl_q, lvl_d;
      logic [8:0] sum9, diff9;
      logic       focused;

      // Next level: a clear beats a same-cycle step; 9-bit math detects
      // overflow past 255 and underflow below 0.
      always_comb begin
         focused = (sel_q == 2'(gi));
         sum9    = {1'b0, lvl_q} + STEP9;
         diff9   = {1'b0, lvl_q} - STEP9;
         lvl_d   = lvl_q;
         if (focused && clear_en) begin
            lvl_d = 8'd0;
         end else if (focused && a_rise) begin
            if (enc_b) begin
               lvl_d = diff9[8] ? 8'd0 : diff9[7:0];
            end else begin
               lvl_d = sum9[8] ? 8'd255 : sum9[7:0];
            end
         end
      end

      // Level register.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            lvl_q <= 8'd0;
         end else begin
            lvl_q <= lvl_d;
         end
      end

      assign level_all[gi] = lvl_q;
   end

   assign level0  = level_all[0];
   assign level1  = level_all[1];
   assign level2  = level_all[2];
   assign sel     = sel_q;
   assign cleared = cleared_q;

endmodule

// File: tb/tb_level_controller.sv
// Testbench for level_controller with STEP = 1 and LONG_CYCLES = 8.
module tb_level_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enc_a = 1'b0;
   logic       enc_b = 1'b0;
   logic       btn = 1'b0;
   logic [7:0] level0, level1, level2;
   logic [1:0] sel;
   logic       cleared;

   int checks = 0;
   int errors = 0;

   level_controller #(.STEP(1), .LONG_CYCLES(8)) dut (
      .clk     (clk),
      .reset   (reset),
      .enc_a   (enc_a),
      .enc_b   (enc_b),
      .btn     (btn),
      .level0  (level0),
      .level1  (level1),
      .level2  (level2),
      .sel     (sel),
      .cleared (cleared)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       a;
      logic       b;
      logic       bt;
      logic [7:0] l0;
      logic [7:0] l1;
      logic [7:0] l2;
      logic [1:0] s;
      logic       c;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic r, input logic a, input logic b, input logic bt,
                               input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                               input logic [1:0] s, input logic c);
      vec_t v;
      v.rst = r; v.a = a; v.b = b; v.bt = bt;
      v.l0 = l0; v.l1 = l1; v.l2 = l2; v.s = s; v.c = c;
      return v;
   endfunction

   function automatic logic [26:0] pack(input logic [7:0] l0, input logic [7:0] l1,
                                        input logic [7:0] l2, input logic [1:0] s, input logic c);
      return {l0, l1, l2, s, c};
   endfunction

   function automatic logic [26:0] outs();
      return {level0, level1, level2, sel, cleared};
   endfunction

   // One clock edge, then sample 1 ns after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [26:0] got, input logic [26:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got l0=%0d l1=%0d l2=%0d sel=%0d clr=%0d, required l0=%0d l1=%0d l2=%0d sel=%0d clr=%0d",
                  nm, got[26:19], got[18:11], got[10:3], got[2:1], got[0],
                  exp[26:19], exp[18:11], exp[10:3], exp[2:1], exp[0]);
      end else begin
         $display("ok   %s: l0=%0d l1=%0d l2=%0d sel=%0d clr=%0d",
                  nm, got[26:19], got[18:11], got[10:3], got[2:1], got[0]);
      end
   endtask

   task automatic chk_int(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", nm, got, exp);
      end else begin
         $display("ok   %s: %0d", nm, got);
      end
   endtask

   task automatic detent(input logic b);
      enc_b = b;
      enc_a = 1'b1;
      cyc();
      enc_a = 1'b0;
      cyc();
   endtask

   task automatic press(input int n);
      btn = 1'b1;
      repeat (n) cyc();
      btn = 1'b0;
      cyc();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();
      cyc();
   endtask

   initial begin
      int pulses;
      int first_clr;

      // {rst, a, b, btn} -> {l0, l1, l2, sel, cleared} after one edge
      vecs[0]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0); // reset, encoder high
      vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0); // unarmed edge
      vecs[2]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0); // no spurious step
      vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 2'd0, 1'b0);
      vecs[4]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0); // up
      vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
      vecs[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0); // up
      vecs[7]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0); // A held: no edge
      vecs[8]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 8'd0, 8'd0, 2'd0, 1'b0);
      vecs[9]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0); // down
      vecs[10] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
      vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0); // press: no focus change
      vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 8'd0, 2'd0, 1'b0);
      vecs[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 8'd0, 2'd1, 1'b0); // release: sel 1
      vecs[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 2'd1, 1'b0); // step on level1
      vecs[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd1, 8'd0, 2'd1, 1'b0);

      for (int i = 0; i < 16; i++) begin
         reset = vecs[i].rst;
         enc_a = vecs[i].a;
         enc_b = vecs[i].b;
         btn   = vecs[i].bt;
         cyc();
         chk($sformatf("vec%0d", i), outs(),
             pack(vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].s, vecs[i].c));
      end
      enc_a = 1'b0; enc_b = 1'b0; btn = 1'b0;

      // Saturation at 255, then back down by 10.
      do_reset();
      repeat (300) detent(1'b0);
      chk("sat_high", outs(), pack(8'd255, 8'd0, 8'd0, 2'd0, 1'b0));
      repeat (10) detent(1'b1);
      chk("down_10", outs(), pack(8'd245, 8'd0, 8'd0, 2'd0, 1'b0));

      // Short presses cycle focus on release.
      press(3);
      chk("short_1", outs(), pack(8'd245, 8'd0, 8'd0, 2'd1, 1'b0));
      press(2);
      chk("short_2", outs(), pack(8'd245, 8'd0, 8'd0, 2'd2, 1'b0));
      press(1);
      chk("short_wrap", outs(), pack(8'd245, 8'd0, 8'd0, 2'd0, 1'b0));
      press(4);
      chk("short_4", outs(), pack(8'd245, 8'd0, 8'd0, 2'd1, 1'b0));
      detent(1'b1);
      chk("sat_low", outs(), pack(8'd245, 8'd0, 8'd0, 2'd1, 1'b0));
      repeat (5) detent(1'b0);
      chk("focus_l1", outs(), pack(8'd245, 8'd5, 8'd0, 2'd1, 1'b0));

      // Long press on level2 = 100: one pulse after the 8th high sample.
      press(2);
      repeat (100) detent(1'b0);
      chk("l2_100", outs(), pack(8'd245, 8'd5, 8'd100, 2'd2, 1'b0));
      pulses = 0;
      btn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (cleared) pulses++;
         if (i == 6) chk("long_7th", outs(), pack(8'd245, 8'd5, 8'd100, 2'd2, 1'b0));
         if (i == 7) chk("long_8th", outs(), pack(8'd245, 8'd5, 8'd0, 2'd2, 1'b1));
      end
      btn = 1'b0;
      cyc();
      chk("long_release", outs(), pack(8'd245, 8'd5, 8'd0, 2'd2, 1'b0));
      chk_int("long_pulses", pulses, 1);

      // Step and clear on the same edge: clear wins.
      repeat (3) detent(1'b0);
      btn = 1'b1;
      repeat (7) cyc();
      chk("clr_step_pre", outs(), pack(8'd245, 8'd5, 8'd3, 2'd2, 1'b0));
      enc_a = 1'b1; enc_b = 1'b0;
      cyc();
      chk("clr_step", outs(), pack(8'd245, 8'd5, 8'd0, 2'd2, 1'b1));
      enc_a = 1'b0; btn = 1'b0;
      cyc();

      // Seven high samples is still a short press.
      press(7);
      chk("short_7", outs(), pack(8'd245, 8'd5, 8'd0, 2'd0, 1'b0));

      // Step and short-press release on the same edge.
      do_reset();
      repeat (5) detent(1'b0);
      btn = 1'b1;
      repeat (3) cyc();
      btn = 1'b0; enc_a = 1'b1; enc_b = 1'b0;
      cyc();
      chk("step_release", outs(), pack(8'd6, 8'd0, 8'd0, 2'd1, 1'b0));
      enc_a = 1'b0;
      cyc();

      // Reset during HELD, then a held button restarts the hold count.
      repeat (3) detent(1'b0);
      btn = 1'b1;
      repeat (10) cyc();
      chk("held_pre", outs(), pack(8'd6, 8'd0, 8'd0, 2'd1, 1'b0));
      reset = 1'b1;
      #1;
      chk("async_reset", outs(), pack(8'd0, 8'd0, 8'd0, 2'd0, 1'b0));
      cyc();
      reset = 1'b0;
      first_clr = -1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (cleared && first_clr < 0) first_clr = i;
      end
      chk_int("restart_hold", first_clr, 8);
      btn = 1'b0;
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
